// File: rtl/hazard_dest_pipe_if.sv
// hazard_dest_pipe_if: ID-side decode inputs and forwarding outputs of the destination pipe
interface hazard_dest_pipe_if #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
);
    logic             freeze;
    logic             valid_id;
    logic [REG_W-1:0] rs_id;
    logic [REG_W-1:0] rt_id;
    logic             uses_rs_id;
    logic             uses_rt_id;
    logic [REG_W-1:0] dest_id;
    logic             writes_id;
    logic             is_load_id;
    logic             stall_id;
    logic [REG_W-1:0] outReg_ex;
    logic             nop_ex;
    logic             is_load_ex;
    logic [REG_W-1:0] outReg_mem;
    logic             nop_mem;
    logic [REG_W-1:0] outReg_wb;
    logic             nop_wb;
    logic [CNT_W-1:0] stall_count;
    modport master (
        output freeze, valid_id, rs_id, rt_id, uses_rs_id, uses_rt_id, dest_id, writes_id, is_load_id,
        input  stall_id, outReg_ex, nop_ex, is_load_ex, outReg_mem, nop_mem, outReg_wb, nop_wb, stall_count
    );
    modport slave (
        input  freeze, valid_id, rs_id, rt_id, uses_rs_id, uses_rt_id, dest_id, writes_id, is_load_id,
        output stall_id, outReg_ex, nop_ex, is_load_ex, outReg_mem, nop_mem, outReg_wb, nop_wb, stall_count
    );
endinterface

// File: rtl/hazard_dest_pipe.sv
// hazard_dest_pipe: carries dest/nop through EX/MEM/WB, detects load-use hazards, counts stalls
module hazard_dest_pipe #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input logic               clk,
    input logic               reset,
    hazard_dest_pipe_if.slave bus
);
    logic hazard;
    logic id_nop;
    always_comb begin
        hazard = bus.valid_id & bus.is_load_ex & ~bus.nop_ex & (bus.outReg_ex != '0) &
                 ((bus.uses_rs_id & (bus.rs_id == bus.outReg_ex)) |
                  (bus.uses_rt_id & (bus.rt_id == bus.outReg_ex)));
        id_nop = ~(bus.valid_id & bus.writes_id & (bus.dest_id != '0));
        bus.stall_id = hazard & ~reset;
    end
    // Writes to $zero enter as nop so forwarding can never match register 0
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.outReg_ex   <= '0;
            bus.nop_ex      <= 1'b1;
            bus.is_load_ex  <= 1'b0;
            bus.outReg_mem  <= '0;
            bus.nop_mem     <= 1'b1;
            bus.outReg_wb   <= '0;
            bus.nop_wb      <= 1'b1;
            bus.stall_count <= '0;
        end else if (!bus.freeze) begin
            bus.outReg_wb   <= bus.outReg_mem;
            bus.nop_wb      <= bus.nop_mem;
            bus.outReg_mem  <= bus.outReg_ex;
            bus.nop_mem     <= bus.nop_ex;
            bus.outReg_ex   <= hazard ? '0 : bus.dest_id;
            bus.nop_ex      <= hazard | id_nop;
            bus.is_load_ex  <= ~hazard & bus.is_load_id & ~id_nop;
            if (hazard && bus.stall_count != {CNT_W{1'b1}})
                bus.stall_count <= bus.stall_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_dest_pipe.sv
// tb_hazard_dest_pipe: directed plus random stimulus against a stage-list reference model
module tb_hazard_dest_pipe;
    logic clk = 0;
    logic reset;
    logic freeze, valid_id, uses_rs_id, uses_rt_id, writes_id, is_load_id;
    logic [4:0] rs_id, rt_id, dest_id;
    int n_assert = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hazard_dest_pipe_if #(.REG_W(5), .CNT_W(16)) u ();
    hazard_dest_pipe_if #(.REG_W(5), .CNT_W(2))  s ();

    assign u.freeze = freeze;      assign s.freeze = freeze;
    assign u.valid_id = valid_id;  assign s.valid_id = valid_id;
    assign u.rs_id = rs_id;        assign s.rs_id = rs_id;
    assign u.rt_id = rt_id;        assign s.rt_id = rt_id;
    assign u.uses_rs_id = uses_rs_id; assign s.uses_rs_id = uses_rs_id;
    assign u.uses_rt_id = uses_rt_id; assign s.uses_rt_id = uses_rt_id;
    assign u.dest_id = dest_id;    assign s.dest_id = dest_id;
    assign u.writes_id = writes_id; assign s.writes_id = writes_id;
    assign u.is_load_id = is_load_id; assign s.is_load_id = is_load_id;

    hazard_dest_pipe #(.REG_W(5), .CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(u.slave));
    hazard_dest_pipe #(.REG_W(5), .CNT_W(2))  dut2 (.clk(clk), .reset(reset), .bus(s.slave));

    typedef struct {
        int  dst;
        bit  nop;
        bit  ld;
    } stage_t;

    stage_t st[3];
    int cnt, cnt2;

    function automatic bit model_hazard();
        return valid_id && st[0].ld && !st[0].nop && st[0].dst != 0 &&
               ((uses_rs_id && rs_id == st[0].dst) || (uses_rt_id && rt_id == st[0].dst));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("stall_id", {31'd0, u.stall_id}, {31'd0, model_hazard() && !reset});
        chk("stall_id_c2", {31'd0, s.stall_id}, {31'd0, model_hazard() && !reset});
        chk("outReg_ex", {27'd0, u.outReg_ex}, st[0].dst);
        chk("nop_ex", {31'd0, u.nop_ex}, {31'd0, st[0].nop});
        chk("is_load_ex", {31'd0, u.is_load_ex}, {31'd0, st[0].ld});
        chk("outReg_mem", {27'd0, u.outReg_mem}, st[1].dst);
        chk("nop_mem", {31'd0, u.nop_mem}, {31'd0, st[1].nop});
        chk("outReg_wb", {27'd0, u.outReg_wb}, st[2].dst);
        chk("nop_wb", {31'd0, u.nop_wb}, {31'd0, st[2].nop});
        chk("stall_count", {16'd0, u.stall_count}, cnt);
        chk("stall_count_c2", {30'd0, s.stall_count}, cnt2);
    endtask

    task automatic model_edge();
        stage_t bubble = '{dst: 0, nop: 1, ld: 0};
        stage_t entry;
        bit hz = model_hazard();
        if (reset) begin
            st = '{bubble, bubble, bubble};
            cnt = 0;
            cnt2 = 0;
        end else if (!freeze) begin
            entry.dst = dest_id;
            entry.nop = !(valid_id && writes_id && dest_id != 0);
            entry.ld  = is_load_id && !entry.nop;
            st[2] = st[1];
            st[1] = st[0];
            st[0] = hz ? bubble : entry;
            if (hz) begin
                cnt  = (cnt  < 65535) ? cnt + 1 : cnt;
                cnt2 = (cnt2 < 3) ? cnt2 + 1 : cnt2;
            end
        end
    endtask

    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic id(input bit v, input int d, input bit wr, input bit ld,
                      input bit urs, input int rs, input bit urt, input int rt);
        valid_id = v; dest_id = 5'(d); writes_id = wr; is_load_id = ld;
        uses_rs_id = urs; rs_id = 5'(rs); uses_rt_id = urt; rt_id = 5'(rt);
    endtask

    initial begin
        int saved;
        st = '{'{0, 1, 0}, '{0, 1, 0}, '{0, 1, 0}};
        cnt = 0;
        cnt2 = 0;
        reset = 1;
        freeze = 0;
        id(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        tick();
        tick();
        #1;
        chk("reset_nop_wb", {31'd0, u.nop_wb}, 32'd1);
        chk("reset_count", {16'd0, u.stall_count}, 32'd0);
        reset = 0;
        // plain flow
        id(1, 5, 1, 0, 0, 0, 0, 0);
        tick();
        id(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        #1;
        chk("flow_wb", {27'd0, u.outReg_wb}, 32'd5);
        chk("flow_nop_wb", {31'd0, u.nop_wb}, 32'd0);
        // load-use
        id(1, 8, 1, 1, 0, 0, 0, 0);
        tick();
        id(1, 9, 1, 0, 0, 0, 1, 8);
        #1;
        chk("lu_stall", {31'd0, u.stall_id}, 32'd1);
        tick();
        #1;
        chk("lu_bubble", {31'd0, u.nop_ex}, 32'd1);
        chk("lu_mem", {27'd0, u.outReg_mem}, 32'd8);
        chk("lu_nop_mem", {31'd0, u.nop_mem}, 32'd0);
        chk("lu_nostall", {31'd0, u.stall_id}, 32'd0);
        chk("lu_count", {16'd0, u.stall_count}, 32'd1);
        tick();
        #1;
        chk("lu_accept", {27'd0, u.outReg_ex}, 32'd9);
        // $zero load
        id(1, 0, 1, 1, 0, 0, 0, 0);
        tick();
        id(1, 6, 1, 0, 1, 0, 0, 0);
        #1;
        chk("zero_nop_ex", {31'd0, u.nop_ex}, 32'd1);
        chk("zero_nostall", {31'd0, u.stall_id}, 32'd0);
        tick();
        // freeze with stages 3/4/5 and a pending hazard on the EX load
        id(1, 3, 1, 0, 0, 0, 0, 0); tick();
        id(1, 4, 1, 0, 0, 0, 0, 0); tick();
        id(1, 5, 1, 1, 0, 0, 0, 0); tick();
        id(1, 7, 1, 0, 1, 5, 0, 0);
        saved = cnt;
        freeze = 1;
        tick(); tick(); tick();
        #1;
        chk("frz_ex", {27'd0, u.outReg_ex}, 32'd5);
        chk("frz_mem", {27'd0, u.outReg_mem}, 32'd4);
        chk("frz_wb", {27'd0, u.outReg_wb}, 32'd3);
        chk("frz_stall", {31'd0, u.stall_id}, 32'd1);
        chk("frz_count", {16'd0, u.stall_count}, 32'(saved));
        freeze = 0;
        tick();
        tick();
        // saturation of the 2-bit counter
        for (int k = 0; k < 5; k++) begin
            id(1, 10 + k, 1, 1, 0, 0, 0, 0); tick();
            id(1, 20, 1, 0, 1, 10 + k, 0, 0); tick();
            tick();
        end
        #1;
        chk("sat_c2", {30'd0, s.stall_count}, 32'd3);
        tick();
        chk("sat_c2_hold", {30'd0, s.stall_count}, 32'd3);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            reset  = ($urandom_range(0, 49) == 0);
            freeze = ($urandom_range(0, 7) == 0);
            id($urandom_range(0, 5) != 0, $urandom_range(0, 7), $urandom_range(0, 4) != 0,
               $urandom_range(0, 2) == 0, $urandom_range(0, 1), $urandom_range(0, 7),
               $urandom_range(0, 1), $urandom_range(0, 7));
            tick();
        end
        reset = 0;
        freeze = 0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
